// File: rtl/axis_demux_1_2.sv
// axis_demux_1_2: packet-locked 1:2 AXI-Stream demux with a registered slice per output
module axis_demux_1_2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [DW-1:0] m1_tdata,
  output logic          m1_tvalid,
  output logic          m1_tlast,
  input  logic          m1_tready,
  output logic [DW-1:0] m2_tdata,
  output logic          m2_tvalid,
  output logic          m2_tlast,
  input  logic          m2_tready,
  output logic          busy
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state, state_nxt;
  logic route_q, eff_route, acc, ld1, ld2;
  assign eff_route = (state == PKT) ? route_q : sel;
  // Only the selected slice gates the input, so a stalled idle output never blocks
  assign s_tready  = rst & (eff_route ? (~m1_tvalid | m1_tready) : (~m2_tvalid | m2_tready));
  assign acc       = s_tvalid & s_tready;
  assign ld1       = acc & eff_route;
  assign ld2       = acc & ~eff_route;
  assign busy      = (state == PKT);
  always_comb begin
    state_nxt = state;
    state_nxt = acc ? (s_tlast ? IDLE : PKT) : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      route_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && acc && !s_tlast) route_q <= sel;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_tdata  <= '0;
      m1_tlast  <= 1'b0;
      m1_tvalid <= 1'b0;
      m2_tdata  <= '0;
      m2_tlast  <= 1'b0;
      m2_tvalid <= 1'b0;
    end else begin
      if (ld1) begin
        m1_tdata  <= s_tdata;
        m1_tlast  <= s_tlast;
        m1_tvalid <= 1'b1;
      end else if (m1_tready) m1_tvalid <= 1'b0;
      if (ld2) begin
        m2_tdata  <= s_tdata;
        m2_tlast  <= s_tlast;
        m2_tvalid <= 1'b1;
      end else if (m2_tready) m2_tvalid <= 1'b0;
    end
  end
endmodule
